// File: rtl/tex_qspi_arbiter.sv
// tex_qspi_arbiter: round-robin arbiter for two byte-read requesters in front of a
// quad-output SPI flash (command and 24-bit address on io0, data nibbles on io[3:0]).
module tex_qspi_arbiter #(
  parameter logic [7:0] CMD   = 8'h6B,
  parameter int         DUMMY = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [23:0] addr0,
  input  logic [23:0] addr1,
  output logic        ack0,
  output logic        ack1,
  output logic [7:0]  rdata,
  output logic        tex_csb,
  output logic        tex_sclk,
  output logic        tex_out0,
  output logic        tex_oeb0,
  input  logic [3:0]  tex_in
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA, ST_DONE
  } state_t;

  // Last cycle index of each state; cnt[0] is the SPI phase (0 = A, 1 = B).
  localparam logic [5:0] CMD_LAST   = 6'd15;
  localparam logic [5:0] ADDR_LAST  = 6'd47;
  localparam logic [5:0] DUMMY_LAST = 6'(2 * DUMMY - 1);
  localparam logic [5:0] DATA_LAST  = 6'd3;

  state_t      state;
  logic [5:0]  cnt;
  logic [30:0] shreg;
  logic [3:0]  nib;
  logic        grant;
  logic        last_grant;
  logic        grant_sel;

  // NOTE: every path assigns grant_sel, so this stays pure logic with no latch.
  always_comb begin
    if (req0 && req1) grant_sel = ~last_grant;
    else              grant_sel = req1;
  end

  // NOTE: all state below uses non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      shreg      <= '0;
      nib        <= '0;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata      <= '0;
      tex_csb    <= 1'b1;
      tex_sclk   <= 1'b0;
      tex_out0   <= 1'b0;
      tex_oeb0   <= 1'b1;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req0 || req1) begin
            state      <= ST_CMD;
            cnt        <= '0;
            grant      <= grant_sel;
            last_grant <= grant_sel;
            // The MSB of CMD goes straight to the pin; the rest queues behind it.
            shreg      <= {CMD[6:0], (grant_sel ? addr1 : addr0)};
            tex_csb    <= 1'b0;
            tex_sclk   <= 1'b0;
            tex_out0   <= CMD[7];
            tex_oeb0   <= 1'b0;
          end
        end
        ST_CMD, ST_ADDR: begin
          cnt      <= cnt + 6'd1;
          tex_sclk <= ~cnt[0];
          if (cnt[0]) begin
            shreg    <= {shreg[29:0], 1'b0};
            tex_out0 <= shreg[30];
          end
          if (state == ST_CMD && cnt == CMD_LAST) begin
            state <= ST_ADDR;
            cnt   <= '0;
          end else if (state == ST_ADDR && cnt == ADDR_LAST) begin
            state    <= (DUMMY == 0) ? ST_DATA : ST_DUMMY;
            cnt      <= '0;
            tex_out0 <= 1'b0;
            tex_oeb0 <= 1'b1;
          end
        end
        ST_DUMMY: begin
          cnt      <= cnt + 6'd1;
          tex_sclk <= ~cnt[0];
          if (cnt == DUMMY_LAST) begin
            state <= ST_DATA;
            cnt   <= '0;
          end
        end
        ST_DATA: begin
          cnt      <= cnt + 6'd1;
          tex_sclk <= ~cnt[0];
          if (cnt == 6'd1) nib <= tex_in;
          if (cnt == DATA_LAST) begin
            state    <= ST_DONE;
            cnt      <= '0;
            rdata    <= {nib, tex_in};
            tex_csb  <= 1'b1;
            tex_sclk <= 1'b0;
            if (grant) ack1 <= 1'b1;
            else       ack0 <= 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tex_qspi_arbiter.sv
// tb_tex_qspi_arbiter: behavioural flash on the SPI pins, a pin-timing monitor, a vector
// table, directed corner sequences and a random run against a rule-level arbitration model.
`timescale 1ns/1ps
module tb_tex_qspi_arbiter;

  localparam int         D    = 8;
  localparam int         D4   = 4;
  localparam logic [7:0] CMDV = 8'h6B;
  localparam int         LAT  = 84;
  localparam int         LAT4 = 76;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1;
  logic [23:0] addr0, addr1;
  logic        ack0, ack1;
  logic [7:0]  rdata;
  logic        tex_csb, tex_sclk, tex_out0, tex_oeb0;
  logic [3:0]  tex_in = 4'h0;

  logic        req0_4;
  logic [23:0] addr0_4;
  logic        ack0_4, ack1_4;
  logic [7:0]  rdata_4;
  logic        csb_4, sclk_4, out0_4, oeb0_4;
  logic [3:0]  tex_in_4 = 4'h9;
  logic        req1_4 = 1'b0;
  logic [23:0] addr1_4 = 24'h0;

  tex_qspi_arbiter #(.CMD(CMDV), .DUMMY(D)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .tex_csb(tex_csb), .tex_sclk(tex_sclk),
    .tex_out0(tex_out0), .tex_oeb0(tex_oeb0), .tex_in(tex_in)
  );

  tex_qspi_arbiter #(.CMD(CMDV), .DUMMY(D4)) dut4 (
    .clk(clk), .reset(reset), .req0(req0_4), .req1(req1_4), .addr0(addr0_4), .addr1(addr1_4),
    .ack0(ack0_4), .ack1(ack1_4), .rdata(rdata_4), .tex_csb(csb_4), .tex_sclk(sclk_4),
    .tex_out0(out0_4), .tex_oeb0(oeb0_4), .tex_in(tex_in_4)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Flash contents are a fixed function of the address it actually received.
  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hC0;
  endfunction

  int          fl_cnt = 0;
  logic [31:0] fl_sh = '0;
  logic [7:0]  rx_cmd = '0;
  logic [23:0] rx_addr = '0;
  logic [7:0]  fl_byte = '0;

  // Flash: samples io0 on rising sclk, presents each data nibble from its rising sclk.
  initial forever begin
    @(posedge tex_sclk or posedge tex_csb);
    if (tex_csb) begin
      fl_cnt = 0;
    end else begin
      if (fl_cnt < 32) fl_sh = {fl_sh[30:0], tex_out0};
      fl_cnt++;
      if (fl_cnt == 32) begin
        rx_cmd  = fl_sh[31:24];
        rx_addr = fl_sh[23:0];
        fl_byte = flash_byte(fl_sh[23:0]);
      end
      if (fl_cnt == 32 + D + 1)      tex_in = fl_byte[7:4];
      else if (fl_cnt == 32 + D + 2) tex_in = fl_byte[3:0];
    end
  end

  // Pin-timing monitor, sampled mid-cycle; k is the cycle index since chip select fell.
  int   k = -1;
  int   viol = 0;
  logic prev_out0 = 1'b0;
  initial forever begin
    @(negedge clk);
    if (reset || tex_csb) begin
      k = -1;
      if (tex_sclk !== 1'b0) viol++;
    end else begin
      k++;
      if (tex_sclk !== k[0]) viol++;
      if (k[0] && tex_out0 !== prev_out0) viol++;
      if (k < 64 && tex_oeb0 !== 1'b0) viol++;
      if (k >= 64 && tex_oeb0 !== 1'b1) viol++;
      if (k >= 64 && k < 64 + 2 * D && tex_out0 !== 1'b0) viol++;
    end
    if (ack0 && ack1) viol++;
    prev_out0 = tex_out0;
  end

  int n_pass = 0;
  int n_chk  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    $display("FAIL %s: DUT event did not occur within its cycle budget", name);
  endtask

  // Observer state refreshed once per mid-cycle sample.
  int   e0_cyc = 0;
  int   ack_cyc = 0;
  int   ack_who = -1;
  bit   e0_now = 1'b0;
  logic prev_csb = 1'b1;

  task automatic tick();
    @(negedge clk);
    ack_who = -1;
    e0_now  = 1'b0;
    if (prev_csb && !tex_csb) begin
      e0_cyc = cyc;
      e0_now = 1'b1;
    end
    if (ack0) begin ack_who = 0; ack_cyc = cyc; end
    if (ack1) begin ack_who = 1; ack_cyc = cyc; end
    prev_csb = tex_csb;
  endtask

  task automatic wait_ack(input int budget, output int who);
    who = -1;
    for (int t = 0; t < budget; t++) begin
      tick();
      if (ack_who >= 0) begin
        who = ack_who;
        break;
      end
    end
    if (who < 0) fail_now("ack_wait");
  endtask

  task automatic wait_e0(input int budget);
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < budget; t++) begin
      tick();
      if (e0_now) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) fail_now("grant_wait");
  endtask

  task automatic do_reset();
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    prev_csb = 1'b1;
  endtask

  // Random-phase arbitration model: rules only, no knowledge of the RTL encoding.
  bit          model_last;
  bit          pred;
  logic [23:0] pred_addr;
  bit          snap0, snap1;
  int          raised, acked;

  task automatic rand_step(input bit allow_raise);
    tick();
    if (e0_now) begin
      pred       = (snap0 && snap1) ? !model_last : snap1;
      pred_addr  = pred ? addr1 : addr0;
      model_last = pred;
    end
    if (ack_who >= 0) begin
      check($sformatf("rand_grant_%0d", acked), ack_who, pred);
      check($sformatf("rand_rdata_%0d", acked), rdata, flash_byte(pred_addr));
      check($sformatf("rand_latency_%0d", acked), ack_cyc - e0_cyc, LAT);
      acked++;
      if (ack_who == 0) req0 = 1'b0;
      else              req1 = 1'b0;
    end else if (allow_raise) begin
      if (!req0 && $urandom_range(0, 2) == 0) begin
        req0 = 1'b1; addr0 = 24'($urandom); raised++;
      end
      if (!req1 && $urandom_range(0, 2) == 0) begin
        req1 = 1'b1; addr1 = 24'($urandom); raised++;
      end
    end
    snap0 = req0;
    snap1 = req1;
  endtask

  typedef struct packed {
    logic        r0;
    logic        r1;
    logic [23:0] a0;
    logic [23:0] a1;
    logic        exp_who;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int          who, prev_ack, extra, e4, a4, rel_cyc;
    bit          got4;
    logic [23:0] exp_addr;

    vecs[0] = '{1'b1, 1'b0, 24'h012345, 24'h000000, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 24'hABCDEF, 24'h100000, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 24'h000000, 24'hFFFFFF, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 24'h000000, 24'h7FFFFF, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 24'h000000, 24'h800001, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 24'hFFFFFF, 24'h000000, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 24'h000001, 24'h000000, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 24'h5A5A5A, 24'hA5A5A5, 1'b1};

    // Reset values hold even with both requests raised.
    reset = 1'b1; req0 = 1'b1; req1 = 1'b1; addr0 = '0; addr1 = '0;
    req0_4 = 1'b0; addr0_4 = 24'h0F0F0F;
    repeat (3) @(negedge clk);
    check("reset_outputs", {tex_csb, tex_sclk, tex_out0, tex_oeb0, ack0, ack1, rdata},
          {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00});
    req0 = 1'b0; req1 = 1'b0;
    reset = 1'b0;

    // Four dummy clocks shorten the transaction by eight cycles.
    req0_4 = 1'b1;
    e4 = -1; a4 = 0; got4 = 1'b0;
    for (int t = 0; t < 300 && !got4; t++) begin
      @(negedge clk);
      if (!csb_4 && e4 < 0) e4 = cyc;
      if (ack0_4) begin
        got4 = 1'b1;
        a4 = cyc;
        check("d4_ack1_low", ack1_4, 1'b0);
      end
    end
    if (!got4) fail_now("d4_ack_wait");
    check("d4_latency", a4 - e4, LAT4);
    check("d4_rdata", rdata_4, 8'h99);
    req0_4 = 1'b0;

    // Vector table: grant choice, data, serial command/address, latency, pulse width.
    for (int i = 0; i < 8; i++) begin
      req0 = vecs[i].r0; req1 = vecs[i].r1;
      addr0 = vecs[i].a0; addr1 = vecs[i].a1;
      wait_ack(300, who);
      exp_addr = vecs[i].exp_who ? vecs[i].a1 : vecs[i].a0;
      check($sformatf("vec%0d_grant", i), who, vecs[i].exp_who);
      check($sformatf("vec%0d_latency", i), ack_cyc - e0_cyc, LAT);
      check($sformatf("vec%0d_rdata", i), rdata, flash_byte(exp_addr));
      check($sformatf("vec%0d_cmd", i), rx_cmd, CMDV);
      check($sformatf("vec%0d_addr", i), rx_addr, exp_addr);
      if (i == 0) check("vec0_rdata_a7", rdata, 8'hA7);
      if (who == 0) req0 = 1'b0;
      else if (who == 1) req1 = 1'b0;
      tick();
      check($sformatf("vec%0d_ack_one_cycle", i), {ack0, ack1}, 2'b00);
    end

    // Tie from reset with both held: 0,1,0,1 and a two-cycle chip-select gap.
    do_reset();
    req0 = 1'b1; addr0 = 24'h111111;
    req1 = 1'b1; addr1 = 24'h222222;
    prev_ack = 0;
    for (int i = 0; i < 4; i++) begin
      wait_ack(300, who);
      check($sformatf("tie%0d_grant", i), who, i % 2);
      check($sformatf("tie%0d_rdata", i), rdata, flash_byte((i % 2) ? addr1 : addr0));
      if (i > 0) check($sformatf("tie%0d_csb_gap", i), e0_cyc - prev_ack, 2);
      prev_ack = ack_cyc;
    end

    // Late arrival during CMD is served on the first IDLE edge after DONE.
    do_reset();
    req0 = 1'b1; addr0 = 24'h13579B;
    wait_e0(10);
    repeat (5) tick();
    req1 = 1'b1; addr1 = 24'h2468AC;
    wait_ack(300, who);
    check("late_first_grant", who, 0);
    req0 = 1'b0;
    prev_ack = ack_cyc;
    wait_ack(300, who);
    check("late_second_grant", who, 1);
    check("late_gap", e0_cyc - prev_ack, 2);
    check("late_rdata", rdata, flash_byte(24'h2468AC));
    req1 = 1'b0;

    // Request dropped during DUMMY still completes, with exactly one ack.
    do_reset();
    req0 = 1'b1; addr0 = 24'hFEDCBA;
    wait_e0(10);
    while (cyc - e0_cyc < 70) tick();
    req0 = 1'b0;
    wait_ack(300, who);
    check("drop_grant", who, 0);
    check("drop_latency", ack_cyc - e0_cyc, LAT);
    check("drop_rdata", rdata, flash_byte(24'hFEDCBA));
    extra = 0;
    repeat (100) begin
      tick();
      if (ack_who >= 0 || e0_now) extra++;
    end
    check("drop_no_extra_activity", extra, 0);

    // Reset in ADDR acts between clock edges; the first post-reset tie goes to req0.
    req0 = 1'b1; addr0 = 24'h0A0B0C;
    wait_e0(10);
    while (cyc - e0_cyc < 30) tick();
    #2 reset = 1'b1;
    req1 = 1'b1; addr1 = 24'h0C0B0A;
    #1;
    check("midreset_async_outputs", {tex_csb, tex_sclk, tex_out0, tex_oeb0, ack0, ack1, rdata},
          {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00});
    tick();
    tick();
    check("midreset_held_idle", {tex_csb, tex_sclk}, 2'b10);
    reset = 1'b0;
    rel_cyc = cyc;
    wait_ack(300, who);
    check("midreset_first_grant", who, 0);
    check("midreset_grant_edge", e0_cyc, rel_cyc + 1);
    check("midreset_latency", ack_cyc - e0_cyc, LAT);
    check("midreset_rdata", rdata, flash_byte(24'h0A0B0C));

    // Random traffic with hold-until-ack requesters, then drain.
    do_reset();
    model_last = 1'b1; raised = 0; acked = 0; snap0 = 1'b0; snap1 = 1'b0;
    for (int t = 0; t < 6000 && acked < 24; t++) rand_step(1'b1);
    for (int t = 0; t < 400 && (req0 || req1); t++) rand_step(1'b0);
    check("rand_drained", {req0, req1}, 2'b00);
    check("rand_no_lost_request", acked, raised);

    check("pin_timing_violations", viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tex_qspi_arbiter.md
TEX_QSPI_ARBITER -- requirements
Module: tex_qspi_arbiter

Interface
REQ-001 SHALL have parameter CMD, default 8'h6B, the flash read command (quad-output fast read).
REQ-002 SHALL have parameter DUMMY, default 8, the number of dummy SPI clocks between address and data.
REQ-003 SHALL have port clk  input  1  system clock; every flop is clocked on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have ports req0, req1  input  1 each  requester read request, held high until ack.
REQ-006 SHALL have ports addr0, addr1  input  24 each  requester byte address, stable while req is high.
REQ-007 SHALL have ports ack0, ack1  output  1 each  one-cycle completion pulse.
REQ-008 SHALL have port rdata  output  8  byte read; valid in the ack cycle and held until the next ack.
REQ-009 SHALL have port tex_csb  output  1  flash chip select, active low.
REQ-010 SHALL have port tex_sclk  output  1  SPI clock.
REQ-011 SHALL have ports tex_out0 and tex_oeb0  output  1 each  io0 data and io0 direction (0=output, 1=input).
REQ-012 SHALL have port tex_in  input  4  io[3:0] input path.

Function
REQ-013 SHALL implement states IDLE, CMD, ADDR, DUMMY, DATA and DONE.
REQ-014 SHALL make each SPI clock two clk cycles: phase A (sclk=0) then phase B (sclk=1).
REQ-015 SHALL change tex_out0 only at the start of phase A.
REQ-016 SHALL register tex_in at the clk edge that ends phase B.
REQ-017 In IDLE with any req high, SHALL at that edge (E0) grant one requester, latch its address, and enter CMD with tex_csb=0.
REQ-018 Arbitration SHALL be round-robin: with both requests high, grant the requester not granted last; after reset req0 wins the first tie.
REQ-019 A single requester SHALL be granted immediately, whatever the last grant was.
REQ-020 CMD SHALL shift the CMD bits MSB first on io0 (tex_oeb0=0) over 8 SPI clocks (16 cycles).
REQ-021 ADDR SHALL shift the latched address MSB first on io0 over 24 SPI clocks (48 cycles).
REQ-022 DUMMY SHALL run for DUMMY SPI clocks with tex_oeb0=1 and tex_out0=0.
REQ-023 DATA SHALL run 2 SPI clocks with tex_oeb0=1: the first captures rdata[7:4], the second rdata[3:4-4]=rdata[3:0] from tex_in[3:0].
REQ-024 At edge E0+84 (DUMMY=8) the block SHALL enter DONE: tex_csb=1, tex_sclk=0, ack of the granted requester=1 for exactly one cycle, rdata updated.
REQ-025 DONE SHALL always return to IDLE, so tex_csb stays high for at least 2 cycles between transactions.
REQ-026 A new request SHALL NOT be sampled in DONE.
REQ-027 Requests arriving during a transaction SHALL wait and are never lost while held high.
REQ-028 If the granted req drops mid-transaction, the transaction SHALL still complete and ack still pulse.
REQ-029 The address SHALL NOT be resampled after grant.
REQ-030 ack0 and ack1 SHALL never be high together.
REQ-031 Bit and phase counters SHALL be sized for 48 cycles, with DUMMY up to 15.
REQ-032 Counter wrap SHALL only ever occur at a state transition.

Reset
REQ-033 While reset is high, and immediately on its assertion including mid-transaction, the block SHALL force state=IDLE, tex_csb=1, tex_sclk=0, tex_out0=0, tex_oeb0=1, ack0=ack1=0, rdata=0 and last-grant=req1.
REQ-034 After reset, the first request SHALL be sampled no earlier than the first clk edge at which reset is low.

Verification
REQ-035 Single read: req0=1, addr0=24'h012345, flash model returns 8'hA7 -> CMD bits 0x6B then 24'h012345 on io0; ack0 pulses at E0+84; rdata=8'hA7; ack1 stays 0.
REQ-036 Tie: req0=req1=1 from reset, with back-to-back transactions -> grants alternate in the order 0,1,0,1; tex_csb is high for at least 2 cycles between transactions.
REQ-037 Late arrival: req1 rises in CMD of a req0 transaction -> req1 is granted on the first IDLE edge after DONE; no request is lost.
REQ-038 Mid-transaction reset: reset asserted in ADDR -> outputs reach reset values without waiting for a clk edge; after reset a new request completes normally in 84 cycles.
REQ-039 Dropped request: req0 falls during DUMMY -> the transaction completes and ack0 pulses once at E0+84.
REQ-040 Timing checker: tex_out0 never changes while tex_sclk=1; tex_oeb0=1 throughout DUMMY and DATA; DUMMY=4 gives ack at E0+76.
